// File: rtl/score_display_ctrl.sv
// score_display_ctrl: update arbiter, BCD converter and digit scanner for the
// 8-digit seven-segment score display used by the Pong game.
// Two score counters request updates (round-robin req/ack). Each accepted
// score is converted to BCD with an iterative double-dabble and stored. The
// stored digits are then time-multiplexed onto the shared SevenSegment decoder.
// After an update, the updated player's digits flash.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank a leading tens zero).
module score_display_ctrl #(
  parameter int SCAN_DIV_BITS  = 17,
  parameter int FLASH_DIV_BITS = 24,
  parameter int FLASH_TOGGLES  = 6
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [1:0] req,
  input  logic [7:0] p1_score,
  input  logic [7:0] p2_score,
  output logic [1:0] ack,
  output logic       busy,
  output logic [3:0] in4,
  output logic [7:0] en_out
);

  localparam int SCAN_W = SCAN_DIV_BITS + 3;
  localparam int FC_W   = $clog2(FLASH_TOGGLES + 1);
  localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLASH_TOGGLES);
  localparam logic [3:0] DIGIT_BLANK = 4'hF;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] TENS_RESET = 4'hF;
`else
  localparam logic [3:0] TENS_RESET = 4'h0;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic              r_grant;      // 0 = player 1, 1 = player 2
  logic              r_ptr;        // round-robin preference for simultaneous requests
  logic [7:0]        r_shift;
  logic [11:0]       r_bcd;
  logic [2:0]        r_bitcnt;
  logic [3:0]        r_p1_tens;
  logic [3:0]        r_p1_ones;
  logic [3:0]        r_p2_tens;
  logic [3:0]        r_p2_ones;
  logic [FC_W-1:0]   r_flash_p1;
  logic [FC_W-1:0]   r_flash_p2;
  logic [SCAN_W-1:0] r_scan;
  logic [FLASH_DIV_BITS-1:0] r_fdiv;
  logic [3:0]        r_in4;
  logic [7:0]        r_en;

  logic              w_any_req;
  logic              w_grant_sel;
  logic [11:0]       w_bcd_next;
  logic [3:0]        w_tens_store;
  logic [3:0]        w_ones_store;
  logic [2:0]        w_slot;
  logic              w_tick;
  logic              w_done_p1;
  logic              w_done_p2;

  function automatic logic [3:0] dabble(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  assign w_any_req   = |req;
  assign w_grant_sel = (&req) ? r_ptr : req[1];

  // The hundreds nibble of an 8-bit value never exceeds 2, so it never needs the +3 correction.
  assign w_bcd_next = {r_bcd[10:8], dabble(r_bcd[7:4]), dabble(r_bcd[3:0]), r_shift[7]};

  // Scores above 99 cannot be shown on two digits and are blanked entirely.
  always_comb begin
    w_tens_store = r_bcd[7:4];
    w_ones_store = r_bcd[3:0];
    if (r_bcd[11:8] != 4'd0) begin
      w_tens_store = DIGIT_BLANK;
      w_ones_store = DIGIT_BLANK;
    end
`ifdef LEADING_ZERO_BLANK_EN
    else if (r_bcd[7:4] == 4'd0) begin
      w_tens_store = DIGIT_BLANK;
    end
`endif
  end

  assign w_done_p1 = (r_state == S_DONE) && !r_grant;
  assign w_done_p2 = (r_state == S_DONE) &&  r_grant;

  assign ack  = {w_done_p2, w_done_p1};
  assign busy = (r_state != S_IDLE);

  // Conversion FSM: grant a requester, double-dabble its score, store the digits.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state   <= S_IDLE;
      r_grant   <= 1'b0;
      r_ptr     <= 1'b0;
      r_shift   <= 8'd0;
      r_bcd     <= 12'd0;
      r_bitcnt  <= 3'd0;
      r_p1_tens <= TENS_RESET;
      r_p1_ones <= 4'd0;
      r_p2_tens <= TENS_RESET;
      r_p2_ones <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant <= w_grant_sel;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_shift  <= r_grant ? p2_score : p1_score;
          r_bcd    <= 12'd0;
          r_bitcnt <= 3'd0;
          r_state  <= S_SHIFT;
        end
        S_SHIFT: begin
          r_bcd    <= w_bcd_next;
          r_shift  <= {r_shift[6:0], 1'b0};
          r_bitcnt <= r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) begin
            r_state <= S_DONE;
          end
        end
        default: begin
          if (r_grant) begin
            r_p2_tens <= w_tens_store;
            r_p2_ones <= w_ones_store;
          end else begin
            r_p1_tens <= w_tens_store;
            r_p1_ones <= w_ones_store;
          end
          r_ptr   <= ~r_grant;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Free-running dividers: the scan counter picks the digit slot, the flash divider paces blinking.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_scan <= '0;
      r_fdiv <= '0;
    end else begin
      r_scan <= r_scan + SCAN_W'(1);
      r_fdiv <= r_fdiv + FLASH_DIV_BITS'(1);
    end
  end

  assign w_slot = r_scan[SCAN_W-1 -: 3];
  assign w_tick = &r_fdiv;

  // Per-player flash countdown; a fresh update reloads it even if a tick lands on the same cycle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_flash_p1 <= '0;
      r_flash_p2 <= '0;
    end else begin
      if (w_done_p1) begin
        r_flash_p1 <= FC_RELOAD;
      end else if (w_tick && (r_flash_p1 != '0)) begin
        r_flash_p1 <= r_flash_p1 - FC_W'(1);
      end
      if (w_done_p2) begin
        r_flash_p2 <= FC_RELOAD;
      end else if (w_tick && (r_flash_p2 != '0)) begin
        r_flash_p2 <= r_flash_p2 - FC_W'(1);
      end
    end
  end

  // Registered digit mux: drive the current slot's digit, blank unused slots and flashing players.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_in4 <= DIGIT_BLANK;
      r_en  <= 8'hFF;
    end else begin
      r_in4 <= DIGIT_BLANK;
      r_en  <= 8'hFF;
      case (w_slot)
        3'd0: begin
          if (!r_flash_p2[0]) begin
            r_en  <= 8'b1111_1110;
            r_in4 <= r_p2_ones;
          end
        end
        3'd1: begin
          if (!r_flash_p2[0]) begin
            r_en  <= 8'b1111_1101;
            r_in4 <= r_p2_tens;
          end
        end
        3'd6: begin
          if (!r_flash_p1[0]) begin
            r_en  <= 8'b1011_1111;
            r_in4 <= r_p1_ones;
          end
        end
        3'd7: begin
          if (!r_flash_p1[0]) begin
            r_en  <= 8'b0111_1111;
            r_in4 <= r_p1_tens;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in4    = r_in4;
  assign en_out = r_en;

endmodule

// File: tb/tb_score_display_ctrl.sv
// tb_score_display_ctrl: self-checking bench for score_display_ctrl.
// Runs with SCAN_DIV_BITS = 2 (32-cycle full scan) and FLASH_DIV_BITS = 4 (16-cycle flash tick).
// Honours LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_score_display_ctrl;

  localparam int SCAN_BITS  = 2;
  localparam int FLASH_BITS = 4;
  localparam int SCAN_LEN   = 1 << (SCAN_BITS + 3);
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] TENS0 = 4'hF;
`else
  localparam logic [3:0] TENS0 = 4'h0;
`endif

  typedef struct {
    logic [1:0] req;
    logic [7:0] p1;
    logic [7:0] p2;
  } vec_t;

  typedef struct {
    logic [1:0] ackExp;
    int         lat;
    logic [3:0] tens;
    logic [3:0] ones;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b1;
  logic [1:0] req = 2'b00;
  logic [7:0] p1_score = 8'd0;
  logic [7:0] p2_score = 8'd0;
  logic [1:0] ack;
  logic       busy;
  logic [3:0] in4;
  logic [7:0] en_out;

  int   nChecks = 0;
  int   nFails = 0;
  int   cyc;
  int   blankCnt = 0;
  exp_t sbq[$];
  logic [3:0] mDig [4];
  logic mPtr;
  vec_t vecs [6];

  score_display_ctrl #(
    .SCAN_DIV_BITS(SCAN_BITS),
    .FLASH_DIV_BITS(FLASH_BITS),
    .FLASH_TOGGLES(6)
  ) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .req(req),
    .p1_score(p1_score),
    .p2_score(p2_score),
    .ack(ack),
    .busy(busy),
    .in4(in4),
    .en_out(en_out)
  );

  always #5 Clk = ~Clk;

  // Edges since reset release; equals the DUT scan position and flash divider phase.
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Count cycles where a player-1 slot is due on the outputs but the digit is blanked.
  always @(negedge Clk) begin
    if (Rst_n && (cyc > 0)) begin
      if (((((cyc - 1) % SCAN_LEN) >> 2) >= 6) && (en_out == 8'hFF)) blankCnt++;
    end
  end

  // Global time bound so the run always ends.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    nChecks++;
    if (actual < lo || actual > hi) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  function automatic logic [7:0] expDigits(input logic [7:0] s);
    logic [7:0] q;
    logic [7:0] r;
    logic [3:0] tens;
    if (s > 8'd99) return 8'hFF;
    q = s / 8'd10;
    r = s % 8'd10;
    tens = q[3:0];
`ifdef LEADING_ZERO_BLANK_EN
    if (tens == 4'd0) tens = 4'hF;
`endif
    return {tens, r[3:0]};
  endfunction

  function automatic logic [7:0] enPattern(input int slot);
    case (slot)
      0: return 8'b1111_1110;
      1: return 8'b1111_1101;
      6: return 8'b1011_1111;
      7: return 8'b0111_1111;
      default: return 8'hFF;
    endcase
  endfunction

  // mDig: 0 = p1 tens, 1 = p1 ones, 2 = p2 tens, 3 = p2 ones
  function automatic logic [3:0] slotDigit(input int slot);
    case (slot)
      0: return mDig[3];
      1: return mDig[2];
      6: return mDig[1];
      7: return mDig[0];
      default: return 4'hF;
    endcase
  endfunction

  task automatic resetModel();
    mDig[0] = TENS0;
    mDig[1] = 4'd0;
    mDig[2] = TENS0;
    mDig[3] = 4'd0;
    mPtr = 1'b0;
  endtask

  task automatic checkSlot(input int slot, input string name);
    bit found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge Clk);
      if (en_out == enPattern(slot)) found = 1;
    end
    if (!found) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL %s: slot enable %0h never seen (last en_out %0h)", name, enPattern(slot), en_out);
    end else begin
      checkOutput(name, in4, slotDigit(slot));
    end
  endtask

  task automatic waitPhase(input int ph);
    for (int i = 0; i < 2 * SCAN_LEN; i++) begin
      @(negedge Clk);
      if ((cyc % SCAN_LEN) == ph) return;
    end
  endtask

  // Drive one request pattern, play both requesters, score acks against the queue.
  task automatic applyStimulus(input vec_t v, input bit checkDisplay);
    exp_t e;
    logic [1:0] pend;
    int g;
    int lat;
    pend = v.req;
    lat = 10;
    while (pend != 2'b00) begin
      g = (pend == 2'b11) ? int'(mPtr) : (pend[1] ? 1 : 0);
      e.ackExp = 2'b01 << g;
      e.lat = lat;
      {e.tens, e.ones} = expDigits((g == 1) ? v.p2 : v.p1);
      sbq.push_back(e);
      pend[g] = 1'b0;
      mPtr = (g == 0);
      lat += 11;
    end
    @(negedge Clk);
    p1_score = v.p1;
    p2_score = v.p2;
    req = v.req;
    for (int n = 1; n <= 30; n++) begin
      @(negedge Clk);
      if (ack != 2'b00) begin
        if (sbq.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL unexpected ack: got %0b at cycle %0d, required none", ack, n);
        end else begin
          e = sbq.pop_front();
          checkOutput("ack grant", {30'd0, ack}, {30'd0, e.ackExp});
          checkOutput("ack latency", n, e.lat);
          if (e.ackExp[0]) begin
            mDig[0] = e.tens;
            mDig[1] = e.ones;
          end else begin
            mDig[2] = e.tens;
            mDig[3] = e.ones;
          end
        end
        req = req & ~ack;
      end
    end
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      nChecks++;
      nFails++;
      $display("[TB] FAIL ack timeout: got none, required %0b", e.ackExp);
    end
    req = 2'b00;
    checkOutput("busy after update", busy, 0);
    if (checkDisplay) begin
      if (v.req[0]) begin
        checkSlot(7, "p1 tens slot7");
        checkSlot(6, "p1 ones slot6");
      end
      if (v.req[1]) begin
        checkSlot(1, "p2 tens slot1");
        checkSlot(0, "p2 ones slot0");
      end
    end
  endtask

  initial begin
    int startCyc;
    int base;
    int sl;
    vec_t v;

    vecs[0] = '{req: 2'b11, p1: 8'd9,   p2: 8'd57};
    vecs[1] = '{req: 2'b01, p1: 8'd42,  p2: 8'd57};
    vecs[2] = '{req: 2'b10, p1: 8'd42,  p2: 8'd100};
    vecs[3] = '{req: 2'b01, p1: 8'd5,   p2: 8'd100};
    vecs[4] = '{req: 2'b11, p1: 8'd63,  p2: 8'd8};
    vecs[5] = '{req: 2'b11, p1: 8'd255, p2: 8'd99};

    $display("[TB] start");
    #1 Rst_n = 1'b0;
    resetModel();
    repeat (3) @(negedge Clk);
    checkOutput("reset ack", {30'd0, ack}, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset in4", in4, 4'hF);
    checkOutput("reset en_out", en_out, 8'hFF);
    Rst_n = 1'b1;
    checkSlot(0, "post-reset slot0");
    checkSlot(1, "post-reset slot1");
    checkSlot(6, "post-reset slot6");
    checkSlot(7, "post-reset slot7");

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], 1);
    end

    // Single player-1 update timed so its blank intervals cover the player-1 slots.
    repeat (120) @(negedge Clk);
    base = blankCnt;
    startCyc = cyc;
    waitPhase(SCAN_LEN - 5);
    v = '{req: 2'b01, p1: 8'd33, p2: 8'd99};
    applyStimulus(v, 1);
    while (cyc < startCyc + 260) @(negedge Clk);
    checkRange("flash blank cycles single update", blankCnt - base, 18, 24);
    base = blankCnt;
    repeat (64) @(negedge Clk);
    checkOutput("flash steady after single update", blankCnt - base, 0);

    // Second update mid-flash restarts the countdown.
    base = blankCnt;
    startCyc = cyc;
    waitPhase(SCAN_LEN - 5);
    v = '{req: 2'b01, p1: 8'd71, p2: 8'd99};
    applyStimulus(v, 0);
    repeat (20) @(negedge Clk);
    waitPhase(SCAN_LEN - 5);
    v = '{req: 2'b01, p1: 8'd18, p2: 8'd99};
    applyStimulus(v, 1);
    while (cyc < startCyc + 330) @(negedge Clk);
    checkRange("flash blank cycles with restart", blankCnt - base, 33, 40);
    base = blankCnt;
    repeat (64) @(negedge Clk);
    checkOutput("flash steady after restart", blankCnt - base, 0);

    // Divider sweep over two full scans.
    for (int i = 0; i < 2 * SCAN_LEN; i++) begin
      @(negedge Clk);
      sl = ((cyc - 1) % SCAN_LEN) >> 2;
      checkOutput($sformatf("sweep slot%0d", sl), {20'd0, en_out, in4},
                  {20'd0, enPattern(sl), slotDigit(sl)});
    end

    // Reset in the middle of a conversion.
    @(negedge Clk);
    p1_score = 8'd77;
    req = 2'b01;
    repeat (4) @(negedge Clk);
    checkOutput("busy during shift", busy, 1);
    #2 Rst_n = 1'b0;
    req = 2'b00;
    #1;
    checkOutput("mid-shift reset ack", {30'd0, ack}, 0);
    checkOutput("mid-shift reset busy", busy, 0);
    checkOutput("mid-shift reset in4", in4, 4'hF);
    checkOutput("mid-shift reset en_out", en_out, 8'hFF);
    resetModel();
    @(negedge Clk);
    Rst_n = 1'b1;
    checkSlot(0, "after abort slot0");
    checkSlot(1, "after abort slot1");
    checkSlot(6, "after abort slot6");
    checkSlot(7, "after abort slot7");
    v = '{req: 2'b11, p1: 8'd3, p2: 8'd64};
    applyStimulus(v, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
